// File: rtl/rs_decode_scheduler.sv
// Round-robin front end sharing one RS(7,5) single-error decoder between two requesters.
// Sequences decoder reset/enable per job and returns the result over a valid/ready channel.
module rs_decode_scheduler #(
    parameter int N            = 7,
    parameter int SYMBOL_WIDTH = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [N*SYMBOL_WIDTH-1:0]   req0_codeword,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [N*SYMBOL_WIDTH-1:0]   req1_codeword,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [N*SYMBOL_WIDTH-1:0]   resp_data,
    output logic                        resp_id,
    output logic                        resp_timeout,
    output logic                        dec_reset,
    output logic                        dec_enable,
    output logic [N*SYMBOL_WIDTH-1:0]   dec_codeword,
    input  logic [N*SYMBOL_WIDTH-1:0]   dec_corrected,
    input  logic                        dec_rdy,
    output logic                        busy
);
    localparam int CW = N * SYMBOL_WIDTH;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] job_cw_q, job_cw_d;
    logic          job_id_q, job_id_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] resp_data_q, resp_data_d;
    logic          resp_to_q, resp_to_d;

    logic idle, gnt_id, accept;

    // On a tie the requester that was not served last wins.
    assign idle   = (state_q == S_IDLE);
    assign gnt_id = (req0_valid && req1_valid) ? ~rr_q : req1_valid;
    assign accept = idle && (req0_valid || req1_valid);

    assign req0_ready   = idle && req0_valid && !gnt_id;
    assign req1_ready   = idle && req1_valid &&  gnt_id;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = resp_data_q;
    assign resp_id      = job_id_q;
    assign resp_timeout = resp_to_q;
    // Decoder is held in reset everywhere but WAIT so stale rdy drains between jobs.
    assign dec_reset    = (state_q != S_WAIT);
    assign dec_enable   = (state_q == S_WAIT);
    assign dec_codeword = job_cw_q;
    assign busy         = !idle;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        job_cw_d    = job_cw_q;
        job_id_d    = job_id_q;
        tcnt_d      = tcnt_q;
        armed_d     = armed_q;
        resp_data_d = resp_data_q;
        resp_to_d   = resp_to_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    job_cw_d = gnt_id ? req1_codeword : req0_codeword;
                    job_id_d = gnt_id;
                    state_d  = S_START;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                armed_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tcnt_d  = (tcnt_q == TLAST) ? tcnt_q : tcnt_q + 1'b1;
                armed_d = armed_q | ~dec_rdy;
                // rdy before the first observed low belongs to the previous job.
                if (dec_rdy && armed_q) begin
                    resp_data_d = dec_corrected;
                    resp_to_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (tcnt_q == TLAST) begin
                    resp_data_d = job_cw_q;
                    resp_to_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            default: begin
                if (resp_ready) begin
                    rr_d    = job_id_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b1;
            job_cw_q    <= '0;
            job_id_q    <= 1'b0;
            tcnt_q      <= '0;
            armed_q     <= 1'b0;
            resp_data_q <= '0;
            resp_to_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            job_cw_q    <= job_cw_d;
            job_id_q    <= job_id_d;
            tcnt_q      <= tcnt_d;
            armed_q     <= armed_d;
            resp_data_q <= resp_data_d;
            resp_to_q   <= resp_to_d;
        end
    end
endmodule

// File: tb/tb_rs_decode_scheduler.sv
// Directed bench for rs_decode_scheduler with a behavioural decoder stub.
module tb_rs_decode_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [20:0] req0_codeword = '0, req1_codeword = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [20:0] resp_data;
    logic        resp_id, resp_timeout;
    logic        dec_reset, dec_enable;
    logic [20:0] dec_codeword, dec_corrected;
    logic        dec_rdy;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;   // 0: rdy after 3 WAIT cycles, 1: rdy tied 0, 2: stale rdy pattern
    int wcyc    = 0;

    always #5 clk = ~clk;

    rs_decode_scheduler #(.N(7), .SYMBOL_WIDTH(3), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_codeword(req0_codeword),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_codeword(req1_codeword),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_timeout(resp_timeout),
        .dec_reset(dec_reset), .dec_enable(dec_enable), .dec_codeword(dec_codeword),
        .dec_corrected(dec_corrected), .dec_rdy(dec_rdy), .busy(busy)
    );

    // Decoder stub: counts cycles since dec_reset dropped.
    always @(posedge clk) begin
        if (dec_reset) wcyc <= 0;
        else           wcyc <= wcyc + 1;
    end
    always_comb begin
        dec_rdy = 1'b0;
        if (!dec_reset) begin
            case (mode)
                1:       dec_rdy = 1'b0;
                2:       dec_rdy = (wcyc == 0) || (wcyc >= 3);
                default: dec_rdy = (wcyc >= 3);
            endcase
        end
    end
    assign dec_corrected = dec_codeword ^ 21'h000001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered in IDLE with valids already driven; runs one job through to the response handshake.
    task automatic do_job(input string tag, input logic exp_id, input logic [20:0] exp_data,
                          input logic exp_to, input int exp_lat, input bit drop);
        int lat;
        chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
        tick();
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        chk({tag, "_start_decrst"}, {31'd0, dec_reset}, 32'd1);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, {11'd0, resp_data}, {11'd0, exp_data});
        chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, exp_id});
        chk({tag, "_to"}, {31'd0, resp_timeout}, {31'd0, exp_to});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        // Reset values
        repeat (2) tick();
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", {11'd0, resp_data}, 32'd0);
        chk("rst_resp_id_to", {30'd0, resp_id, resp_timeout}, 32'd0);
        chk("rst_dec", {30'd0, dec_reset, dec_enable}, 32'd2);
        chk("rst_busy_ready", {29'd0, busy, req1_ready, req0_ready}, 32'd0);
        reset = 1'b1;
        tick();

        // Single job from req0
        req0_valid = 1'b1; req0_codeword = 21'h0ABCDE; #1;
        do_job("single", 1'b0, 21'h0ABCDF, 1'b0, 5, 1'b1);

        // Timeout on req1
        mode = 1;
        req1_valid = 1'b1; req1_codeword = 21'h155555; #1;
        do_job("tmo", 1'b1, 21'h155555, 1'b1, 16, 1'b1);

        // Contention: rr now 1 so ids go 0,1,0,1
        mode = 0;
        req0_valid = 1'b1; req0_codeword = 21'h000010;
        req1_valid = 1'b1; req1_codeword = 21'h000020; #1;
        for (int i = 0; i < 4; i++)
            do_job("cont", i[0], i[0] ? 21'h000021 : 21'h000011, 1'b0, 5, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Back-pressure
        req0_valid = 1'b1; req0_codeword = 21'h000333; #1;
        tick();
        req0_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin tick(); lat++; end
        chk("bp_lat", lat, 5);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_data", {11'd0, resp_data}, 32'h000332);
            chk("bp_id_to", {30'd0, resp_id, resp_timeout}, 32'd0);
            chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        chk("bp_single_resp", seen, 0);
        chk("bp_busy", {31'd0, busy}, 32'd0);

        // Stale rdy on first WAIT cycle must be ignored
        mode = 2;
        req0_valid = 1'b1; req0_codeword = 21'h000040; #1;
        do_job("stale", 1'b0, 21'h000041, 1'b0, 5, 1'b1);

        // Reset mid-WAIT; rr is 0 here, reset must restore it to 1
        mode = 1;
        req0_valid = 1'b1; req0_codeword = 21'h000777; #1;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        chk("mid_enable", {31'd0, dec_enable}, 32'd1);
        reset = 1'b0; #1;
        chk("mid_async", {29'd0, dec_reset, dec_enable, busy}, 32'd4);
        tick();
        reset = 1'b1; #1;
        chk("mid_resp", {30'd0, resp_valid, resp_timeout}, 32'd0);
        chk("mid_data", {11'd0, resp_data}, 32'd0);
        chk("mid_id", {31'd0, resp_id}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid || busy) seen++;
            tick();
        end
        chk("mid_noresp", seen, 0);
        mode = 0;
        req0_valid = 1'b1; req0_codeword = 21'h000010;
        req1_valid = 1'b1; req1_codeword = 21'h000020; #1;
        do_job("post_rst", 1'b0, 21'h000011, 1'b0, 5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
